// File: rtl/eeprom_access_arbiter_if.sv
// rtl/eeprom_access_arbiter_if.sv - controller-side bus between the arbiter and the I2C EEPROM controller
//
// master: arbiter side (drives device/register address, write data, control word)
// slave : controller side (drives status word and read data)
//   o_dev_addr [6:0]   7-bit I2C device address
//   o_reg_addr [15:0]  EEPROM byte address of the granted request
//   o_w_data   [31:0]  write data of the granted request
//   o_ctrl     [31:0]  [0] enable, [3:1] op, [6:4] clock rate, [7] clear
//   i_status   [31:0]  [1] finish, [9:2] controller state, [10] sm_enable
//   i_rd_data  [31:0]  {byte0, byte1, byte2, byte3}
interface eeprom_access_arbiter_if;
    logic [6:0]  o_dev_addr;
    logic [15:0] o_reg_addr;
    logic [31:0] o_w_data;
    logic [31:0] o_ctrl;
    logic [31:0] i_status;
    logic [31:0] i_rd_data;

    modport master (
        output o_dev_addr, o_reg_addr, o_w_data, o_ctrl,
        input  i_status, i_rd_data
    );

    modport slave (
        input  o_dev_addr, o_reg_addr, o_w_data, o_ctrl,
        output i_status, i_rd_data
    );
endinterface

// File: rtl/eeprom_access_arbiter.sv
// rtl/eeprom_access_arbiter.sv - round-robin sharing of one I2C EEPROM controller between two requesters
//
// Ports:
//   i_clk, i_rst               clock, synchronous active-high reset
//   i_a_* / o_a_*              requester A (CPU register path): req/rw/addr/wdata in, done/err/rdata out
//   i_b_* / o_b_*              requester B (boot parameter loader), same shape as A
//   ctl                        controller bus (eeprom_access_arbiter_if.master)
//   o_busy                     high whenever the arbiter is not idle
//   o_txn_cnt, o_err_cnt       completion counters, present only with EEPROM_ARB_STATS_EN defined
//
// Optional feature macro: EEPROM_ARB_STATS_EN
module eeprom_access_arbiter #(
    parameter logic [6:0]  DEV_ADDR     = 7'h50,
    parameter logic [2:0]  CLK_RATE     = 3'd7,
    parameter int unsigned CLR_HOLD_CYC = 1024,
    parameter int unsigned TWR_CYC      = 500000,
    parameter int unsigned TIMEOUT_CYC  = 2000000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_a_req,
    input  logic        i_a_rw,
    input  logic [15:0] i_a_addr,
    input  logic [31:0] i_a_wdata,
    output logic        o_a_done,
    output logic        o_a_err,
    output logic [31:0] o_a_rdata,
    input  logic        i_b_req,
    input  logic        i_b_rw,
    input  logic [15:0] i_b_addr,
    input  logic [31:0] i_b_wdata,
    output logic        o_b_done,
    output logic        o_b_err,
    output logic [31:0] o_b_rdata,
    eeprom_access_arbiter_if.master ctl,
    output logic        o_busy
`ifdef EEPROM_ARB_STATS_EN
    ,
    output logic [15:0] o_txn_cnt,
    output logic [15:0] o_err_cnt
`endif
);

    localparam logic [20:0] TMO_LIM = 21'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        S_FLUSH,
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_CLEAR,
        S_RESP,
        S_HOLDOFF
    } state_t;

    state_t      state, state_n;
    logic        owner;       // 0 = A, 1 = B
    logic        owner_vld;   // 0 while clearing after reset: nobody to answer
    logic        last_grant;
    logic        op_rd;
    logic        err;
    logic [31:0] rd_buf;
    logic [31:0] cnt;         // cycles spent in the current state
    logic [20:0] tmo_cnt;
    logic [15:0] reg_addr;
    logic [31:0] w_data;

    logic finish, ctrl_busy, tmo_hit, clr_hold_done, twr_done, grant_b, clr_bit, resp_ok_rd;

    assign finish        = ctl.i_status[1];
    assign ctrl_busy     = ctl.i_status[10] || (ctl.i_status[9:2] != 8'd0);
    assign tmo_hit       = tmo_cnt >= TMO_LIM;
    assign clr_hold_done = cnt >= CLR_HOLD_CYC;
    assign twr_done      = (cnt + 32'd1) >= TWR_CYC;
    assign clr_bit       = (state == S_CLEAR) && !clr_hold_done;

    // Tie goes to whoever was not granted last.
    assign grant_b = i_b_req && (!i_a_req || !last_grant);

    // Leaving CLEAR towards RESP with finish low and no earlier error on a read.
    assign resp_ok_rd = (state == S_CLEAR) && (state_n == S_RESP) && op_rd && !err && !finish;

    logic unused_status;
    assign unused_status = &{1'b0, ctl.i_status[31:11], ctl.i_status[0]};

    always_comb begin
        state_n = state;
        case (state)
            S_FLUSH:     if (!ctrl_busy) state_n = S_CLEAR;
            S_IDLE:      if (i_a_req || i_b_req) state_n = S_ISSUE;
            // Drop enable as soon as the controller has picked it up so it is not retriggered.
            S_ISSUE:     if (ctrl_busy || tmo_hit) state_n = (ctrl_busy ? S_WAIT_DONE : S_CLEAR);
            // Back in state 0 without finish means the controller gave up (NACK).
            S_WAIT_DONE: if (finish || !ctrl_busy || tmo_hit) state_n = S_CLEAR;
            S_CLEAR:     if (clr_hold_done && (!finish || tmo_hit))
                             state_n = owner_vld ? S_RESP : S_IDLE;
            S_RESP:      state_n = (!op_rd && !err) ? S_HOLDOFF : S_IDLE;
            S_HOLDOFF:   if (twr_done) state_n = S_IDLE;
            default:     state_n = S_FLUSH;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_FLUSH;
            owner      <= 1'b0;
            owner_vld  <= 1'b0;
            last_grant <= 1'b1;
            op_rd      <= 1'b0;
            err        <= 1'b0;
            rd_buf     <= '0;
            cnt        <= '0;
            tmo_cnt    <= '0;
            reg_addr   <= '0;
            w_data     <= '0;
            o_a_rdata  <= '0;
            o_b_rdata  <= '0;
            o_busy     <= 1'b0;
        end else begin
            state  <= state_n;
            o_busy <= (state_n != S_IDLE);
            cnt    <= (state_n != state) ? 32'd0 : cnt + 32'd1;

            // The bound restarts at each issue and again for the clear handshake.
            if ((state_n != state) && ((state_n == S_ISSUE) || (state_n == S_CLEAR)))
                tmo_cnt <= '0;
            else if (tmo_cnt != '1)
                tmo_cnt <= tmo_cnt + 21'd1;

            if ((state == S_IDLE) && (state_n == S_ISSUE)) begin
                owner      <= grant_b;
                last_grant <= grant_b;
                owner_vld  <= 1'b1;
                err        <= 1'b0;
                op_rd      <= grant_b ? i_b_rw    : i_a_rw;
                reg_addr   <= grant_b ? i_b_addr  : i_a_addr;
                w_data     <= grant_b ? i_b_wdata : i_a_wdata;
            end

            if ((state == S_ISSUE) && !ctrl_busy && tmo_hit)
                err <= 1'b1;

            if (state == S_WAIT_DONE) begin
                if (finish) begin
                    if (op_rd) rd_buf <= ctl.i_rd_data;
                    err <= 1'b0;
                end else if (!ctrl_busy || tmo_hit) begin
                    err <= 1'b1;
                end
            end

            // Finish still high when CLEAR gives up means the clear handshake timed out.
            if ((state == S_CLEAR) && (state_n != S_CLEAR) && finish)
                err <= 1'b1;

            if (resp_ok_rd) begin
                if (owner) o_b_rdata <= rd_buf;
                else       o_a_rdata <= rd_buf;
            end
        end
    end

`ifdef EEPROM_ARB_STATS_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_txn_cnt <= '0;
            o_err_cnt <= '0;
        end else if (state == S_RESP) begin
            if (!err && (o_txn_cnt != 16'hFFFF)) o_txn_cnt <= o_txn_cnt + 16'd1;
            if (err && (o_err_cnt != 16'hFFFF))  o_err_cnt <= o_err_cnt + 16'd1;
        end
    end
`endif

    assign o_a_done = (state == S_RESP) && !owner;
    assign o_b_done = (state == S_RESP) && owner;
    assign o_a_err  = o_a_done && err;
    assign o_b_err  = o_b_done && err;

    assign ctl.o_dev_addr = DEV_ADDR;
    assign ctl.o_reg_addr = reg_addr;
    assign ctl.o_w_data   = w_data;
    assign ctl.o_ctrl     = {24'd0, clr_bit, CLK_RATE, 2'b00, op_rd, (state == S_ISSUE)};

endmodule

// File: tb/tb_eeprom_access_arbiter.sv
// tb/tb_eeprom_access_arbiter.sv - scoreboard bench for eeprom_access_arbiter with a behavioural controller
module tb_eeprom_access_arbiter;
    localparam int CLR_HOLD = 8;
    localparam int TWR      = 100;
    localparam int TMO      = 200;
    localparam int BUDGET   = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_req = 0, a_rw = 0, b_req = 0, b_rw = 0;
    logic [15:0] a_addr = 0, b_addr = 0;
    logic [31:0] a_wdata = 0, b_wdata = 0;
    logic        a_done, a_err, b_done, b_err, busy;
    logic [31:0] a_rdata, b_rdata;
`ifdef EEPROM_ARB_STATS_EN
    logic [15:0] txn_cnt, err_cnt;
`endif

    eeprom_access_arbiter_if bus();

    eeprom_access_arbiter #(
        .DEV_ADDR(7'h50), .CLK_RATE(3'd7), .CLR_HOLD_CYC(CLR_HOLD),
        .TWR_CYC(TWR), .TIMEOUT_CYC(TMO)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_a_req(a_req), .i_a_rw(a_rw), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
        .o_a_done(a_done), .o_a_err(a_err), .o_a_rdata(a_rdata),
        .i_b_req(b_req), .i_b_rw(b_rw), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
        .o_b_done(b_done), .o_b_err(b_err), .o_b_rdata(b_rdata),
        .ctl(bus),
        .o_busy(busy)
`ifdef EEPROM_ARB_STATS_EN
        , .o_txn_cnt(txn_cnt), .o_err_cnt(err_cnt)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return (a == 16'h0100) ? 32'h11223344 : {16'hA5A5, a};
    endfunction

    // Controller model: mode 0 finishes, 1 hangs busy, 2 returns to idle without finish.
    int          mode = 0;
    int          mcnt = 0;
    logic        mbusy = 1'b0, mfin = 1'b0;
    logic [15:0] maddr = '0;
    logic [31:0] mdata = '0;

    always @(posedge clk) begin
        if (bus.o_ctrl[7]) begin
            mbusy <= 1'b0;
            mfin  <= 1'b0;
        end else if (mbusy) begin
            mcnt <= mcnt + 1;
            if (mode != 1 && mcnt >= 5) begin
                mbusy <= 1'b0;
                mfin  <= (mode == 0);
                mdata <= mem_word(maddr);
            end
        end else if (bus.o_ctrl[0] && !mfin) begin
            mbusy <= 1'b1;
            mcnt  <= 0;
            maddr <= bus.o_reg_addr;
        end
    end

    assign bus.i_status  = {21'd0, mbusy, (mbusy ? 8'h03 : 8'h00), mfin, 1'b0};
    assign bus.i_rd_data = mdata;

    int n_checks = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    typedef struct {
        bit          who;
        bit          err;
        logic [31:0] rdata;
    } exp_t;
    exp_t exp_q[$];

    int          done_cnt = 0, since_done = 0, since_issue = 0, since_nack = 1000;
    int          issue_gap = 0, last_lat = 0, last_nack_gap = 0, clr_run = 0, last_clr_len = 0;
    logic [15:0] issue_addr = '0;
    logic [31:0] issue_wdata = '0, issue_ctrl = '0;
    logic        prev_en = 0, prev_clr = 0, prev_mbusy = 0;

    always @(negedge clk) begin
        exp_t e;
        since_done++;
        since_issue++;
        since_nack++;
        if (bus.o_ctrl[0] && !prev_en) begin
            issue_gap   = since_done;
            since_issue = 0;
            issue_addr  = bus.o_reg_addr;
            issue_wdata = bus.o_w_data;
            issue_ctrl  = bus.o_ctrl;
        end
        if (bus.o_ctrl[7]) clr_run++;
        else if (prev_clr) begin
            last_clr_len = clr_run;
            clr_run = 0;
        end
        if (prev_mbusy && !mbusy && !mfin && mode == 2) since_nack = 0;
        if (a_done || b_done) begin
            done_cnt++;
            last_lat      = since_issue;
            last_nack_gap = since_nack;
            since_done    = 0;
            if (a_done && b_done) chk("done_overlap", 1, 0);
            if (exp_q.size() == 0) chk("done_unexpected", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("done_owner", b_done, e.who);
                chk("done_err", b_done ? b_err : a_err, e.err);
                chk("done_rdata", b_done ? b_rdata : a_rdata, e.rdata);
            end
        end
        prev_en    = bus.o_ctrl[0];
        prev_clr   = bus.o_ctrl[7];
        prev_mbusy = mbusy;
    end

    logic [31:0] exp_a_rdata = '0, exp_b_rdata = '0;

    task automatic push_exp(input bit who, input bit rw, input logic [15:0] addr, input bit err);
        exp_t e;
        if (rw && !err) begin
            if (who) exp_b_rdata = mem_word(addr);
            else     exp_a_rdata = mem_word(addr);
        end
        e.who   = who;
        e.err   = err;
        e.rdata = who ? exp_b_rdata : exp_a_rdata;
        exp_q.push_back(e);
    endtask

    // Holds the request until done, then releases it and steps one cycle past done.
    task automatic run_req(input bit who, input bit rw, input logic [15:0] addr, input logic [31:0] wd);
        bit got = 0;
        @(negedge clk);
        if (who) begin b_req = 1; b_rw = rw; b_addr = addr; b_wdata = wd; end
        else     begin a_req = 1; a_rw = rw; a_addr = addr; a_wdata = wd; end
        for (int i = 0; i < BUDGET && !got; i++) begin
            @(negedge clk);
            got = who ? b_done : a_done;
        end
        if (!got) chk(who ? "b_done_timeout" : "a_done_timeout", 0, 1);
        if (who) b_req = 0; else a_req = 0;
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_a_done"}, a_done, 0);
        chk({tag, "_b_done"}, b_done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ctrl"}, bus.o_ctrl, 32'h0000_0070);
        chk({tag, "_dev_addr"}, bus.o_dev_addr, 7'h50);
        chk({tag, "_reg_addr"}, bus.o_reg_addr, 0);
        chk({tag, "_w_data"}, bus.o_w_data, 0);
        chk({tag, "_a_rdata"}, a_rdata, 0);
        chk({tag, "_b_rdata"}, b_rdata, 0);
`ifdef EEPROM_ARB_STATS_EN
        chk({tag, "_txn_cnt"}, txn_cnt, 0);
        chk({tag, "_err_cnt"}, err_cnt, 0);
`endif
    endtask

    initial begin
        bit tb_last = 1;
        int done_before;
        bit seen;

        repeat (3) @(negedge clk);
        check_reset_vals("rst0");
        rst = 0;
        repeat (CLR_HOLD + 12) @(negedge clk);
        chk("post_flush_idle", busy, 0);
        chk("post_flush_no_done", done_cnt, 0);

        // A write: latched fields, holdoff before the next grant.
        push_exp(0, 0, 16'h0010, 0); tb_last = 0;
        run_req(0, 0, 16'h0010, 32'hDEADBEEF);
        chk("wr_reg_addr", issue_addr, 16'h0010);
        chk("wr_w_data", issue_wdata, 32'hDEADBEEF);
        chk("wr_op", issue_ctrl[3:1], 0);
        chk("wr_holdoff_busy", busy, 1);

        // B read right behind it must wait out the holdoff; no holdoff after a read.
        push_exp(1, 1, 16'h0100, 0); tb_last = 1;
        run_req(1, 1, 16'h0100, 32'h0);
        chk("holdoff_gap_ok", (issue_gap >= TWR), 1);
        chk("rd_op", issue_ctrl[3:1], 1);
        chk("rd_idle_after", busy, 0);

        // Simultaneous requests: tie goes to the requester not granted last.
        for (int r = 0; r < 4; r++) begin
            logic [15:0] aa, ba;
            aa = 16'h0020 + 16'(r);
            ba = 16'h0030 + 16'(r);
            if (tb_last) begin push_exp(0, 1, aa, 0); push_exp(1, 1, ba, 0); end
            else         begin push_exp(1, 1, ba, 0); push_exp(0, 1, aa, 0); end
            fork
                run_req(0, 1, aa, 32'h0);
                run_req(1, 1, ba, 32'h0);
            join
        end

        // Controller never finishes: timeout error, read data held, full clear pulse.
        mode = 1;
        push_exp(0, 1, 16'h0040, 1); tb_last = 0;
        run_req(0, 1, 16'h0040, 32'h0);
        chk("tmo_latency_ok", (last_lat >= TMO), 1);
        chk("tmo_clr_len", last_clr_len, CLR_HOLD);
        mode = 0;

        // NACK on a write: error soon after the controller drops out, no holdoff.
        mode = 2;
        push_exp(1, 0, 16'h0050, 1); tb_last = 1;
        run_req(1, 0, 16'h0050, 32'hCAFEF00D);
        chk("nack_gap_ok", (last_nack_gap <= CLR_HOLD + 10), 1);
        chk("nack_clr_len", last_clr_len, CLR_HOLD);
        chk("nack_idle_after", busy, 0);
        mode = 0;

        // Reset in WAIT_DONE with the controller busy.
        mode = 1;
        done_before = done_cnt;
        @(negedge clk);
        a_req = 1; a_rw = 1; a_addr = 16'h0060;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = mbusy;
        end
        chk("rst_ctrl_busy_seen", seen, 1);
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);
        a_req = 0;
        check_reset_vals("rst1");
        repeat (2) @(negedge clk);
        rst = 0;
        last_clr_len = 0;
        repeat (20) @(negedge clk);
        chk("flush_no_clear", bus.o_ctrl[7], 0);
        chk("flush_busy", busy, 1);
        mode = 0;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = !busy;
        end
        chk("flush_back_idle", seen, 1);
        chk("flush_clr_len", last_clr_len, CLR_HOLD);
        chk("flush_no_done", done_cnt, done_before);
        chk("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
